// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with registered Moore strobes.
// Optional macro CONTROL_FSM_ILLEGAL_TRAP_EN: trap illegal opcodes into HALT and expose the sticky illegal flag.
module control_fsm #(
  parameter int INSTR_WIDTH  = 16,
  parameter int OP_WIDTH     = 4,
  parameter int ALU_OP_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [INSTR_WIDTH-1:0]  instr,
  input  logic                    imem_valid,
  input  logic                    dmem_ready,
  output logic                    instr_req,
  output logic                    halted,
  output logic                    reg_write_en,
  output logic                    itype,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    dmem_req,
  output logic                    dmem_we,
  output logic                    pc_en
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  ,output logic                   illegal
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_LSL  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_LD   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_ST   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(6);

  state_t                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [OP_WIDTH-1:0]    op_q, op_d;
  logic                   illegal_q, illegal_d;

  logic instr_req_q, instr_req_d;
  logic halted_q, halted_d;
  logic reg_write_en_q, reg_write_en_d;
  logic dmem_req_q, dmem_req_d;
  logic dmem_we_q, dmem_we_d;
  logic pc_en_q, pc_en_d;

  logic unused_ir_operand_bits;
  assign unused_ir_operand_bits = ^ir_q[INSTR_WIDTH-OP_WIDTH-1:0];

  assign op_q = ir_q[INSTR_WIDTH-1 -: OP_WIDTH];
  assign op_d = ir_d[INSTR_WIDTH-1 -: OP_WIDTH];

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (imem_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_HALT:                        state_d = S_HALT;
          OP_ADD, OP_LSL, OP_ADDI, OP_NOP: state_d = S_EXEC;
          OP_LD, OP_ST:                   state_d = S_MEM;
          default: begin
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            state_d   = S_EXEC;
`endif
          end
        endcase
      end
      S_EXEC:  state_d = S_FETCH;
      S_MEM: begin
        if (dmem_ready) state_d = (op_q == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Strobes are registered from the next state so they are valid for the whole state cycle;
    // a completed store advances the PC during the following FETCH cycle.
    instr_req_d    = (state_d == S_FETCH);
    halted_d       = (state_d == S_HALT);
    reg_write_en_d = (state_d == S_WB) ||
                     ((state_d == S_EXEC) && (op_d == OP_ADD || op_d == OP_LSL || op_d == OP_ADDI));
    dmem_req_d     = (state_d == S_MEM);
    dmem_we_d      = (state_d == S_MEM) && (op_d == OP_ST);
    pc_en_d        = (state_d == S_EXEC) || (state_d == S_WB) ||
                     ((state_q == S_MEM) && (state_d == S_FETCH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_FETCH;
      ir_q           <= '0;
      illegal_q      <= 1'b0;
      instr_req_q    <= 1'b1;
      halted_q       <= 1'b0;
      reg_write_en_q <= 1'b0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      pc_en_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      ir_q           <= ir_d;
      illegal_q      <= illegal_d;
      instr_req_q    <= instr_req_d;
      halted_q       <= halted_d;
      reg_write_en_q <= reg_write_en_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      pc_en_q        <= pc_en_d;
    end
  end

  assign instr_req    = instr_req_q;
  assign halted       = halted_q;
  assign reg_write_en = reg_write_en_q;
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign pc_en        = pc_en_q;
  assign alu_op       = (op_q == OP_LSL) ? ALU_OP_WIDTH'(1) : '0;
  assign itype        = (op_q == OP_ADDI) || (op_q == OP_LD) || (op_q == OP_ST);

`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  assign illegal = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm; output vector is {instr_req,halted,reg_write_en,itype,alu_op,dmem_req,dmem_we,pc_en}.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        imem_valid = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        instr_req, halted, reg_write_en, itype, dmem_req, dmem_we, pc_en;
  logic [1:0]  alu_op;
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [8:0] V_IDLE = 9'b1_0_0_0_00_0_0_0;

  logic [8:0] obs;
  assign obs = {instr_req, halted, reg_write_en, itype, alu_op, dmem_req, dmem_we, pc_en};

  control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .instr_req(instr_req), .halted(halted), .reg_write_en(reg_write_en), .itype(itype),
    .alu_op(alu_op), .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_en(pc_en)
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  // Leaves rst_n released just after a falling edge, so the next rising edge is the first fetch.
  task automatic do_reset();
    rst_n = 1'b0; imem_valid = 1'b0; dmem_ready = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_valid = 1'b1; instr = 16'h1000;
    @(negedge clk);
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_hold: got %b expected %b", obs, V_IDLE); end
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    n_checks++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
`endif
    imem_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, V_IDLE); end
    $display("test_reset done");
  endtask

  task automatic test_add();
    do_reset();
    instr = 16'h1000; imem_valid = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0_0_0_0_00_0_0_0) begin n_fail++; $display("FAIL add_decode: got %b expected 000000000", obs); end
    instr = 16'h2000;  // must be ignored outside FETCH
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0_0_1_0_00_0_0_1) begin n_fail++; $display("FAIL add_exec: got %b expected 001000001", obs); end
    imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL add_refetch: got %b expected %b", obs, V_IDLE); end
    $display("test_add done");
  endtask

  task automatic test_lsl_addi();
    logic [15:0] ins [2];
    logic [8:0]  exp [2][3];
    ins[0] = 16'h2000; exp[0][0] = 9'b0_0_0_0_01_0_0_0; exp[0][1] = 9'b0_0_1_0_01_0_0_1; exp[0][2] = 9'b1_0_0_0_01_0_0_0;
    ins[1] = 16'h3000; exp[1][0] = 9'b0_0_0_1_00_0_0_0; exp[1][1] = 9'b0_0_1_1_00_0_0_1; exp[1][2] = 9'b1_0_0_1_00_0_0_0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      instr = ins[k]; imem_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        imem_valid = 1'b0;
        n_checks++;
        if (obs !== exp[k][c]) begin
          n_fail++; $display("FAIL lsl_addi instr=%h cyc=%0d: got %b expected %b", ins[k], c, obs, exp[k][c]);
        end
      end
    end
    $display("test_lsl_addi done");
  endtask

  task automatic test_ld();
    do_reset();
    instr = 16'h4000; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    n_checks++;
    if (obs !== 9'b0_0_0_1_00_0_0_0) begin n_fail++; $display("FAIL ld_decode: got %b expected 000100000", obs); end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (obs !== 9'b0_0_0_1_00_1_0_0) begin n_fail++; $display("FAIL ld_mem cyc=%0d: got %b expected 000100100", i, obs); end
      dmem_ready = (i == 3);
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    n_checks++;
    if (obs !== 9'b0_0_1_1_00_0_0_1) begin n_fail++; $display("FAIL ld_wb: got %b expected 001100001", obs); end
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b1_0_0_1_00_0_0_0) begin n_fail++; $display("FAIL ld_refetch: got %b expected 100100000", obs); end
    $display("test_ld done");
  endtask

  task automatic test_st();
    do_reset();
    instr = 16'h5000; imem_valid = 1'b1; dmem_ready = 1'b1;  // ready during DECODE is ignored
    @(negedge clk);
    imem_valid = 1'b0;
    n_checks++;
    if (obs !== 9'b0_0_0_1_00_0_0_0) begin n_fail++; $display("FAIL st_decode: got %b expected 000100000", obs); end
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0_0_0_1_00_1_1_0) begin n_fail++; $display("FAIL st_mem: got %b expected 000100110", obs); end
    @(negedge clk);
    dmem_ready = 1'b0;
    n_checks++;
    if (obs !== 9'b1_0_0_1_00_0_0_1) begin n_fail++; $display("FAIL st_pc_en: got %b expected 100100001", obs); end
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b1_0_0_1_00_0_0_0) begin n_fail++; $display("FAIL st_fetch: got %b expected 100100000", obs); end
    $display("test_st done");
  endtask

  task automatic test_halt();
    do_reset();
    instr = 16'h0000; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    n_checks++;
    if (obs !== 9'b0) begin n_fail++; $display("FAIL halt_decode: got %b expected 000000000", obs); end
    instr = 16'h1000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_valid = ~imem_valid;
      n_checks++;
      if (obs !== 9'b0_1_0_0_00_0_0_0) begin n_fail++; $display("FAIL halt_sticky cyc=%0d: got %b expected 010000000", i, obs); end
    end
    imem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL halt_async_reset: got %b expected %b", obs, V_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL halt_after_reset: got %b expected %b", obs, V_IDLE); end
    $display("test_halt done");
  endtask

  task automatic test_illegal();
    do_reset();
    instr = 16'hF000; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    n_checks++;
    if (obs !== 9'b0) begin n_fail++; $display("FAIL illegal_decode: got %b expected 000000000", obs); end
    @(negedge clk);
`ifdef CONTROL_FSM_ILLEGAL_TRAP_EN
    n_checks++;
    if (obs !== 9'b0_1_0_0_00_0_0_0 || illegal !== 1'b1) begin
      n_fail++; $display("FAIL illegal_trap: got %b/%b expected 010000000/1", obs, illegal);
    end
    @(negedge clk);
    n_checks++;
    if (illegal !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b expected 1", illegal); end
`else
    n_checks++;
    if (obs !== 9'b0_0_0_0_00_0_0_1) begin n_fail++; $display("FAIL illegal_nop: got %b expected 000000001", obs); end
    @(negedge clk);
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL illegal_refetch: got %b expected %b", obs, V_IDLE); end
`endif
    $display("test_illegal done");
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    instr = 16'h4000; imem_valid = 1'b1;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== 9'b0_0_0_1_00_1_0_0) begin n_fail++; $display("FAIL midmem_enter: got %b expected 000100100", obs); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== V_IDLE) begin n_fail++; $display("FAIL midmem_async_drop: got %b expected %b", obs, V_IDLE); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset_mid_mem done");
  endtask

  task automatic test_back_to_back();
    do_reset();
    instr = 16'h6000; imem_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 2) instr = 16'h1000;
      n_checks++;
      case (c % 3)
        0: if (obs[0] !== 1'b0 || obs[6] !== 1'b0) begin n_fail++; $display("FAIL b2b_decode cyc=%0d: got %b", c, obs); end
        1: if (obs !== {2'b00, (c == 4), 6'b000001}) begin
             n_fail++; $display("FAIL b2b_exec cyc=%0d: got %b expected %b", c, obs, {2'b00, (c == 4), 6'b000001});
           end
        default: if (obs !== V_IDLE) begin n_fail++; $display("FAIL b2b_fetch cyc=%0d: got %b expected %b", c, obs, V_IDLE); end
      endcase
    end
    imem_valid = 1'b0;
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_add();
    test_lsl_addi();
    test_ld();
    test_st();
    test_halt();
    test_illegal();
    test_reset_mid_mem();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
